// File: rtl/ZionDataType.sv
// Shared types for the execute scheduler: unit codes, latencies, reservation entry, div FSM state.
package ZionDataType;

    localparam int unsigned LatSingle     = 1;
    localparam int unsigned LatNone       = 0;
    localparam int unsigned MulLatDefault = 2;
    localparam int unsigned DivLatDefault = 33;

    typedef enum logic [2:0] {
        UnitLogic  = 3'd0,
        UnitShift  = 3'd1,
        UnitMul    = 3'd2,
        UnitDiv    = 3'd3,
        UnitAdd    = 3'd4,
        UnitMem    = 3'd5,
        UnitBranch = 3'd6
    } unit_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] sel;
        logic [4:0] rd;
    } res_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } div_state_e;

    // Zero means the unit never claims the writeback port.
    function automatic int unsigned unit_lat(logic [2:0] unit, int unsigned mul_lat,
                                             int unsigned div_lat);
        int unsigned lat;
        case (unit)
            UnitLogic, UnitShift, UnitAdd: lat = LatSingle;
            UnitMul:                       lat = mul_lat;
            UnitDiv:                       lat = div_lat;
            default:                       lat = LatNone;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/ex_sched_if.sv
// Dispatch/writeback bundle between the issue stage and the execute scheduler.
interface ex_sched_if;

    logic       iss_valid;
    logic [2:0] iss_unit;
    logic [4:0] iss_rd;
    logic       iss_rd_we;
    logic [4:0] iss_rs1;
    logic [4:0] iss_rs2;
    logic       iss_rs1_use;
    logic       iss_rs2_use;
    logic       flush;
    logic       iss_ready;
    logic       div_start;
    logic       div_busy;
    logic       wb_valid;
    logic [2:0] wb_sel;
    logic [4:0] wb_rd;

    modport master (
        output iss_valid, iss_unit, iss_rd, iss_rd_we, iss_rs1, iss_rs2,
        output iss_rs1_use, iss_rs2_use, flush,
        input  iss_ready, div_start, div_busy, wb_valid, wb_sel, wb_rd
    );

    modport slave (
        input  iss_valid, iss_unit, iss_rd, iss_rd_we, iss_rs1, iss_rs2,
        input  iss_rs1_use, iss_rs2_use, flush,
        output iss_ready, div_start, div_busy, wb_valid, wb_sel, wb_rd
    );

endinterface

// File: rtl/ex_sched_div_fsm.sv
// Occupancy tracker for the single iterative divider: IDLE -> RUN -> DONE -> IDLE.
module ex_sched_div_fsm
    import ZionDataType::*;
#(
    parameter int unsigned DIV_LAT = DivLatDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic flush_i,
    output logic busy_o,
    output logic done_o
);

    localparam logic [5:0] CntLast = 6'(DIV_LAT - 2);

    div_state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RUN lasts DIV_LAT-1 cycles so DONE lines up with the div writeback slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);

endmodule

// File: rtl/ex_sched.sv
// Execute scheduler: writeback reservation table plus issue stalls; optional RAW interlock
// when EX_SCHED_RAW_EN is defined.
module ex_sched
    import ZionDataType::*;
#(
    parameter int unsigned MUL_LAT = MulLatDefault,
    parameter int unsigned DIV_LAT = DivLatDefault
) (
    input  logic       clk,
    input  logic       rst,
    ex_sched_if.slave  bus_io
);

    res_entry_t  tab_q   [DIV_LAT];
    res_entry_t  tab_d   [DIV_LAT];
    res_entry_t  shifted [DIV_LAT];
    int unsigned lat;
    logic        needs_slot;
    logic        slot_busy;
    logic        raw_hazard;
    logic        is_div;
    logic        accept;
    logic        div_busy;
    logic        div_done;

    always_comb begin
        for (int unsigned k = 0; k < DIV_LAT - 1; k++) begin
            shifted[k] = tab_q[k + 1];
        end
        shifted[DIV_LAT - 1] = '0;
    end

    always_comb begin
        lat        = unit_lat(bus_io.iss_unit, MUL_LAT, DIV_LAT);
        needs_slot = bus_io.iss_rd_we && (lat != 0);
        slot_busy  = 1'b0;
        for (int unsigned k = 0; k < DIV_LAT; k++) begin
            if (k == lat - 1) begin
                slot_busy = shifted[k].valid;
            end
        end
    end

`ifdef EX_SCHED_RAW_EN
    // Entry 0 is writing back this cycle and is covered by the bypass network.
    always_comb begin
        raw_hazard = 1'b0;
        for (int unsigned k = 1; k < DIV_LAT; k++) begin
            if (tab_q[k].valid && (tab_q[k].rd != 5'd0)) begin
                if (bus_io.iss_rs1_use && (bus_io.iss_rs1 == tab_q[k].rd)) begin
                    raw_hazard = 1'b1;
                end
                if (bus_io.iss_rs2_use && (bus_io.iss_rs2 == tab_q[k].rd)) begin
                    raw_hazard = 1'b1;
                end
            end
        end
    end
`else
    logic unused_rs;
    assign raw_hazard = 1'b0;
    assign unused_rs  = ^{bus_io.iss_rs1, bus_io.iss_rs2, bus_io.iss_rs1_use,
                          bus_io.iss_rs2_use};
`endif

    assign is_div = (bus_io.iss_unit == UnitDiv);

    assign bus_io.iss_ready = !rst && !bus_io.flush && !(needs_slot && slot_busy) &&
                              !(is_div && div_busy) && !raw_hazard;

    assign accept           = bus_io.iss_valid && bus_io.iss_ready;
    assign bus_io.div_start = accept && is_div;

    always_comb begin
        tab_d = shifted;
        if (bus_io.flush) begin
            for (int unsigned k = 0; k < DIV_LAT; k++) begin
                tab_d[k] = '0;
            end
        end else if (accept && needs_slot) begin
            for (int unsigned k = 0; k < DIV_LAT; k++) begin
                if (k == lat - 1) begin
                    tab_d[k] = res_entry_t'{valid: 1'b1, sel: bus_io.iss_unit,
                                            rd: bus_io.iss_rd};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DIV_LAT; k++) begin
                tab_q[k] <= '0;
            end
        end else begin
            tab_q <= tab_d;
        end
    end

    // x0 writes keep their slot reserved but never signal a writeback.
    assign bus_io.wb_valid = tab_q[0].valid && (tab_q[0].rd != 5'd0);
    assign bus_io.wb_sel   = tab_q[0].sel;
    assign bus_io.wb_rd    = tab_q[0].rd;
    assign bus_io.div_busy = div_busy;

    ex_sched_div_fsm #(
        .DIV_LAT (DIV_LAT)
    ) u_div_fsm (
        .clk     (clk),
        .rst     (rst),
        .start_i (bus_io.div_start),
        .flush_i (bus_io.flush),
        .busy_o  (div_busy),
        .done_o  (div_done)
    );

    logic unused_done;
    assign unused_done = div_done;

endmodule

// File: tb/tb_ex_sched.sv
// Directed bench for ex_sched with MUL_LAT=2, DIV_LAT=33.
module tb_ex_sched;
    import ZionDataType::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   hits;
    logic raw_on;

    always #5 clk = ~clk;

    ex_sched_if bus ();

    ex_sched #(
        .MUL_LAT (2),
        .DIV_LAT (33)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic v, input logic [2:0] sel,
                            input logic [4:0] rd);
        check({tag, "_valid"}, 32'(bus.wb_valid), 32'(v));
        if (v) begin
            check({tag, "_sel"}, 32'(bus.wb_sel), 32'(sel));
            check({tag, "_rd"}, 32'(bus.wb_rd), 32'(rd));
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic v, input logic [2:0] unit, input logic [4:0] rd,
                         input logic we, input logic [4:0] rs1, input logic use1,
                         input logic fl);
        @(negedge clk);
        bus.iss_valid   = v;
        bus.iss_unit    = unit;
        bus.iss_rd      = rd;
        bus.iss_rd_we   = we;
        bus.iss_rs1     = rs1;
        bus.iss_rs1_use = use1;
        bus.iss_rs2     = 5'd0;
        bus.iss_rs2_use = 1'b0;
        bus.flush       = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
`ifdef EX_SCHED_RAW_EN
        raw_on = 1'b1;
`else
        raw_on = 1'b0;
`endif
        rst             = 1'b1;
        bus.iss_valid   = 1'b1;
        bus.iss_unit    = UnitAdd;
        bus.iss_rd      = 5'd5;
        bus.iss_rd_we   = 1'b1;
        bus.iss_rs1     = 5'd0;
        bus.iss_rs2     = 5'd0;
        bus.iss_rs1_use = 1'b0;
        bus.iss_rs2_use = 1'b0;
        bus.flush       = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.iss_ready), 0);
        check("rst_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_wb_sel", 32'(bus.wb_sel), 0);
        check("rst_wb_rd", 32'(bus.wb_rd), 0);
        check("rst_div_start", 32'(bus.div_start), 0);
        check("rst_div_busy", 32'(bus.div_busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle add
        drive(1'b1, UnitAdd, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        check("add_ready", 32'(bus.iss_ready), 1);
        idle();
        check_wb("add_wb", 1'b1, 3'd4, 5'd5);
        idle();
        check_wb("add_wb_once", 1'b0, 3'd0, 5'd0);

        // Mul then add colliding on the writeback port
        drive(1'b1, UnitMul, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        check("mul_ready", 32'(bus.iss_ready), 1);
        drive(1'b1, UnitAdd, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        check("add_slot_stall", 32'(bus.iss_ready), 0);
        check_wb("mul_wb_early", 1'b0, 3'd0, 5'd0);
        drive(1'b1, UnitAdd, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        check("add_after_stall", 32'(bus.iss_ready), 1);
        check_wb("mul_wb", 1'b1, 3'd2, 5'd7);
        idle();
        check_wb("add_wb2", 1'b1, 3'd4, 5'd8);
        idle();
        check_wb("wb_drain", 1'b0, 3'd0, 5'd0);

        // rd=0 still reserves its slot but never writes back
        drive(1'b1, UnitMul, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        drive(1'b1, UnitAdd, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
        check("rd0_slot_stall", 32'(bus.iss_ready), 0);
        drive(1'b1, UnitAdd, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
        check("rd0_add_ready", 32'(bus.iss_ready), 1);
        check_wb("rd0_wb", 1'b0, 3'd0, 5'd0);
        idle();
        check_wb("rd0_add_wb", 1'b1, 3'd4, 5'd4);

        // Mem claims no slot, so it issues under a pending mul
        drive(1'b1, UnitMul, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        drive(1'b1, UnitMem, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
        check("mem_ready", 32'(bus.iss_ready), 1);
        idle();
        check_wb("mem_mul_wb", 1'b1, 3'd2, 5'd9);
        idle();
        check_wb("mem_no_wb", 1'b0, 3'd0, 5'd0);

        // Division: busy window and second-div stall
        drive(1'b1, UnitDiv, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        check("div_ready", 32'(bus.iss_ready), 1);
        check("div_start", 32'(bus.div_start), 1);
        check("div_busy_c0", 32'(bus.div_busy), 0);
        for (int c = 1; c <= 33; c++) begin
            drive(1'b1, UnitDiv, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
            check($sformatf("div_busy_c%0d", c), 32'(bus.div_busy), 1);
            check($sformatf("div2_stall_c%0d", c), 32'(bus.iss_ready), 0);
            check($sformatf("div_start_off_c%0d", c), 32'(bus.div_start), 0);
            check_wb($sformatf("div_wb_c%0d", c), (c == 33), 3'd3, 5'd9);
        end
        drive(1'b1, UnitDiv, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
        check("div2_ready_c34", 32'(bus.iss_ready), 1);
        check("div2_start_c34", 32'(bus.div_start), 1);
        check("div_busy_c34", 32'(bus.div_busy), 0);

        // Flush kills the second division mid-flight
        for (int c = 1; c <= 9; c++) begin
            idle();
        end
        check("div2_busy_c9", 32'(bus.div_busy), 1);
        drive(1'b1, UnitAdd, 5'd11, 1'b1, 5'd0, 1'b0, 1'b1);
        check("flush_blocks_issue", 32'(bus.iss_ready), 0);
        drive(1'b1, UnitDiv, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0);
        check("flush_busy_clear", 32'(bus.div_busy), 0);
        check("div3_ready", 32'(bus.iss_ready), 1);
        check("div3_start", 32'(bus.div_start), 1);
        check_wb("flush_wb_clear", 1'b0, 3'd0, 5'd0);
        hits = 0;
        for (int c = 12; c <= 43; c++) begin
            idle();
            if (bus.wb_valid) hits++;
        end
        check("flush_no_div_wb", 32'(hits), 0);
        idle();
        check_wb("div3_wb", 1'b1, 3'd3, 5'd11);
        idle();
        check("div3_idle", 32'(bus.div_busy), 0);

        // Writeback presented in the flush cycle stands
        drive(1'b1, UnitDiv, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0);
        check("div4_ready", 32'(bus.iss_ready), 1);
        drive(1'b1, UnitAdd, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
        check("add_under_div", 32'(bus.iss_ready), 1);
        drive(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        check_wb("wb_with_flush", 1'b1, 3'd4, 5'd6);
        idle();
        check_wb("wb_after_flush", 1'b0, 3'd0, 5'd0);
        check("div4_killed", 32'(bus.div_busy), 0);
        hits = 0;
        for (int c = 0; c < 33; c++) begin
            idle();
            if (bus.wb_valid) hits++;
        end
        check("div4_no_wb", 32'(hits), 0);

        // RAW on rs1 against an in-flight mul (rd_we=0 so no slot is needed)
        drive(1'b1, UnitMul, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        drive(1'b1, UnitAdd, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        check("raw_c1", 32'(bus.iss_ready), raw_on ? 32'd0 : 32'd1);
        drive(1'b1, UnitAdd, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        check("raw_c2", 32'(bus.iss_ready), 1);
        drive(1'b1, UnitMul, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        drive(1'b1, UnitAdd, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0);
        check("raw_unused_rs", 32'(bus.iss_ready), 1);
        idle();
        idle();

        // Asynchronous reset during div RUN
        drive(1'b1, UnitDiv, 5'd14, 1'b1, 5'd0, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        drive(1'b1, UnitAdd, 5'd15, 1'b1, 5'd0, 1'b0, 1'b0);
        check("pre_rst_add_ready", 32'(bus.iss_ready), 1);
        idle();
        check_wb("pre_rst_wb", 1'b1, 3'd4, 5'd15);
        check("pre_rst_busy", 32'(bus.div_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wb_valid", 32'(bus.wb_valid), 0);
        check("arst_wb_sel", 32'(bus.wb_sel), 0);
        check("arst_wb_rd", 32'(bus.wb_rd), 0);
        check("arst_div_busy", 32'(bus.div_busy), 0);
        check("arst_div_start", 32'(bus.div_start), 0);
        check("arst_ready", 32'(bus.iss_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            idle();
            if (bus.wb_valid) hits++;
        end
        check("arst_no_div_wb", 32'(hits), 0);
        check("arst_busy_stays_low", 32'(bus.div_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_sched.md
EX_SCHED -- requirements
Module: ex_sched

Interface
REQ-001 Parameters SHALL be: MUL_LAT, default 2, mul issue-to-writeback cycles (1..4); DIV_LAT, default 33, div issue-to-writeback cycles (MUL_LAT+1..63).
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 iss_valid  in  1  dispatch offers one op this cycle.
REQ-005 iss_unit  in  3  target unit code 0..6 (0 logic, 1 shift, 2 mul, 3 div, 4 add, 5 mem, 6 branch).
REQ-006 iss_rd  in  5  destination register; iss_rd_we  in  1  op writes iss_rd.
REQ-007 iss_rs1, iss_rs2  in  5 each  source registers; iss_rs1_use, iss_rs2_use  in  1 each.
REQ-008 flush  in  1  branch/exception kill of all in-flight ops.
REQ-009 iss_ready  out  1  op accepted when iss_valid and iss_ready are both high.
REQ-010 div_start  out  1  one-cycle start pulse to the div unit; div_busy  out  1  div unit occupied.
REQ-011 wb_valid  out  1; wb_sel  out  3  result-select index into ExResult; wb_rd  out  5.

Function
REQ-012 Unit latency L SHALL be 1 for units 0/1/4, MUL_LAT for 2, DIV_LAT for 3; units 5/6 SHALL reserve no writeback slot.
REQ-013 The block SHALL keep a reservation table of DIV_LAT entries {valid, sel, rd}; entry k represents writeback k cycles ahead.
REQ-014 Each cycle the table SHALL shift one entry toward the head; the head SHALL drive wb_valid/wb_sel/wb_rd from a register (writeback appears exactly L cycles after the accept edge).
REQ-015 An accepted op with iss_rd_we=1 and L>0 SHALL load entry L-1 after the shift; iss_rd=0 SHALL still reserve the slot but with wb_valid forced low at writeback.
REQ-016 iss_ready SHALL be low when entry L-1 (post-shift) is already valid for the offered unit (structural hazard on the single writeback port).
REQ-017 iss_ready SHALL be low for unit 3 while div_busy=1; only one div in flight.
REQ-018 Div FSM states: IDLE, RUN, DONE; IDLE->RUN on div accept (div_start=1 that cycle), RUN counts DIV_LAT-1 cycles then ->DONE, DONE->IDLE next cycle coinciding with div writeback; div_busy=1 in RUN and DONE.
REQ-019 iss_ready SHALL be combinational from current state and iss_* only, never from wb_* outputs.
REQ-020 flush SHALL clear all table entries and return the FSM to IDLE at that edge; an op offered during flush SHALL NOT be accepted (iss_ready=0); wb_valid SHALL be 0 the cycle after flush.
REQ-021 Flush and a completing writeback in the same cycle: the writeback presented that cycle SHALL stand; nothing later.

Reset
REQ-022 On rst: table empty, FSM IDLE, wb_valid=0, wb_sel=0, wb_rd=0, div_start=0, div_busy=0; iss_ready SHALL be 0 while rst is high.
REQ-023 rst mid-division SHALL abandon the division with no writeback.

Configuration
REQ-024 With EX_SCHED_RAW_EN defined, iss_ready SHALL also be low when a used, nonzero rs1/rs2 equals rd of any valid table entry other than the one writing back this cycle (bypass covers it).
REQ-025 Without EX_SCHED_RAW_EN, rs ports SHALL be ignored and only structural/div-busy stalls apply.

Structure
REQ-026 Unit codes, their latency constants and the reservation-entry struct SHALL live in ZionDataType.
REQ-027 Div FSM SHALL be sub-module ex_sched_div_fsm (start, flush, busy, done); table and issue logic stay in ex_sched.

Verification
REQ-028 Add (unit 4, rd=5) accepted cycle 0 -> wb_valid=1, wb_sel=4, wb_rd=5 at cycle 1 only.
REQ-029 Mul rd=7 accepted cycle 0, add offered cycle 1 -> with MUL_LAT=2 add stalls cycle 1 (slot 2 taken), accepted cycle 2; writebacks rd=7 cycle 2, add cycle 3.
REQ-030 Div rd=9 accepted cycle 0 -> div_start pulse cycle 0, div_busy 1..33, second div stalled until cycle 34, wb_rd=9 wb_sel=3 at cycle 33.
REQ-031 Div accepted, flush at cycle 10 -> no div writeback, div_busy=0 at cycle 11, new div accepted cycle 11.
REQ-032 EX_SCHED_RAW_EN on: mul rd=3 cycle 0, add rs1=3 cycle 1 -> stalled cycle 1, accepted cycle 2; off: accepted cycle 1.
REQ-033 rst asserted asynchronously during div RUN -> all outputs zero before the next clock edge.
